inst_cache_dm: RTL and testbench



---
 rtl/inst_cache_dm_pkg.sv | 20 ++
 rtl/inst_cache_refill.sv | 91 +++++++++
 rtl/inst_cache_dm.sv | 111 +++++++++++
 tb/tb_inst_cache_dm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_dm_pkg.sv
// Shared widths, default geometry and refill state encoding for the
// direct-mapped instruction cache.
package inst_cache_dm_pkg;

    localparam int Inst_Width        = 32;
    localparam int Inst_Addr_Width   = 17;
    localparam int ICache_Line_Words = 4;
    localparam int ICache_Num_Lines  = 32;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_t;

    // Memory words arrive in file byte order; fetch wants them reversed.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// Line refill engine: walks one cache line through the word-wide memory
// handshake and tells the arrays which word to write and when to validate.
module inst_cache_refill
    import inst_cache_dm_pkg::*;
#(
    parameter int ADDR_WIDTH = Inst_Addr_Width,
    parameter int LINE_WORDS = ICache_Line_Words
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss,
    input  logic [ADDR_WIDTH-1:0]         line_base,
    input  logic                          flush,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_data,
    output logic                          idle,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [ADDR_WIDTH-1:0]         fill_addr,
    output logic                          wr_en,
    output logic [$clog2(LINE_WORDS)-1:0] wr_word,
    output logic [31:0]                   wr_data,
    output logic                          set_valid
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

    icache_state_t           state, state_n;
    logic [WB-1:0]           cnt, cnt_n;
    logic                    kill, kill_n;
    logic [ADDR_WIDTH-1:0]   fill_addr_n;

    // State register plus the latched line address, word count and kill flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ICACHE_IDLE;
            cnt       <= '0;
            kill      <= 1'b0;
            fill_addr <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            kill      <= kill_n;
            fill_addr <= fill_addr_n;
        end
    end

    // Next-state and handshake outputs; a flush mid-refill only poisons validation.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        kill_n      = kill;
        fill_addr_n = fill_addr;
        mem_req     = 1'b0;
        mem_addr    = '0;
        wr_en       = 1'b0;
        set_valid   = 1'b0;
        unique case (state)
            ICACHE_IDLE: begin
                if (miss) begin
                    fill_addr_n = line_base;
                    cnt_n       = '0;
                    state_n     = ICACHE_FILL;
                end
            end
            ICACHE_FILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr + ADDR_WIDTH'({cnt, 2'b00});
                if (flush) begin
                    kill_n = 1'b1;
                end
                if (mem_ack) begin
                    wr_en = 1'b1;
                    cnt_n = cnt + WB'(1);
                    if (cnt == LAST_WORD) begin
                        set_valid = !kill && !flush;
                        kill_n    = 1'b0;
                        state_n   = ICACHE_IDLE;
                    end
                end
            end
            default: state_n = ICACHE_IDLE;
        endcase
    end

    assign idle    = (state == ICACHE_IDLE);
    assign wr_word = cnt;
    assign wr_data = mem_data;

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache: tag/valid/data arrays, hit compare and the
// byte-swapped fetch output, with refills delegated to inst_cache_refill.
module inst_cache_dm
    import inst_cache_dm_pkg::*;
#(
    parameter int ADDR_WIDTH = Inst_Addr_Width,
    parameter int LINE_WORDS = ICache_Line_Words,
    parameter int NUM_LINES  = ICache_Num_Lines
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  pc_cache_stall,
    input  logic                  flush,
    output logic [Inst_Width-1:0] inst,
    output logic                  cache_enable,
    output logic                  icache_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_data
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = ADDR_WIDTH - 2 - WB - IB;

    logic [NUM_LINES-1:0]  valid;
    logic [TW-1:0]         tag_mem  [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES][LINE_WORDS];

    logic [WB-1:0]         addr_word;
    logic [IB-1:0]         addr_idx;
    logic [TW-1:0]         addr_tag;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [IB-1:0]         fill_idx;
    logic [TW-1:0]         fill_tag;
    logic                  idle, hit, miss;
    logic                  wr_en, set_valid;
    logic [WB-1:0]         wr_word;
    logic [31:0]           wr_data, rd_word;
    logic                  unused_bits;

    assign addr_word = addr[WB+1:2];
    assign addr_idx  = addr[WB+IB+1:WB+2];
    assign addr_tag  = addr[ADDR_WIDTH-1:WB+IB+2];
    assign line_base = {addr[ADDR_WIDTH-1:WB+2], {(WB+2){1'b0}}};
    assign fill_idx  = fill_addr[WB+IB+1:WB+2];
    assign fill_tag  = fill_addr[ADDR_WIDTH-1:WB+IB+2];
    assign unused_bits = ^{addr[1:0], fill_addr[WB+1:0]};

    assign rd_word      = data_mem[addr_idx][addr_word];
    assign hit          = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag) && idle;
    assign miss         = ce && !pc_cache_stall && !hit;
    assign icache_stall = miss;

    inst_cache_refill #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk       (clk),
        .rst       (rst),
        .miss      (miss),
        .line_base (line_base),
        .flush     (flush),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .idle      (idle),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .fill_addr (fill_addr),
        .wr_en     (wr_en),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .set_valid (set_valid)
    );

    // Valid bits: flush beats a completing refill on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (set_valid) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Data and tag storage; contents are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[fill_idx][wr_word] <= wr_data;
        end
        if (set_valid) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    // Fetch output: zeros unless enabled, unstalled and hitting.
    always_comb begin
        inst         = '0;
        cache_enable = 1'b0;
        if (ce && !pc_cache_stall && hit) begin
            inst         = byte_swap(rd_word);
            cache_enable = (rd_word[25:24] == 2'b11);
        end
    end

endmodule

// File: tb/tb_inst_cache_dm.sv
// Self-checking bench for inst_cache_dm: directed scenarios followed by
// random fetches, checked against a line-residency model of the cache.
module tb_inst_cache_dm;

    localparam int AW = 17;
    localparam int LW = 4;
    localparam int NL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [AW-1:0] addr;
    logic          pc_cache_stall;
    logic          flush;
    logic [31:0]   inst;
    logic          cache_enable;
    logic          icache_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_data = 32'h0;

    logic          flush_main;
    logic          flush_resp = 1'b0;
    assign flush = flush_main | flush_resp;

    logic [31:0]   mem [0:(1<<(AW-2))-1];
    int            gap;
    int            flush_at;
    int            ack_total = 0;
    int            wait_cnt = 0;
    int            checks;
    int            errors;
    bit            model_valid [NL];
    int            model_tag [NL];
    logic [AW-1:0] ack_log [$];

    always #5 clk = ~clk;

    inst_cache_dm #(
        .ADDR_WIDTH (AW),
        .LINE_WORDS (LW),
        .NUM_LINES  (NL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .addr           (addr),
        .pc_cache_stall (pc_cache_stall),
        .flush          (flush),
        .inst           (inst),
        .cache_enable   (cache_enable),
        .icache_stall   (icache_stall),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data)
    );

    // Memory responder: acks after 'gap' idle cycles, can fire a flush on a chosen ack.
    initial begin
        forever begin
            @(negedge clk);
            flush_resp = 1'b0;
            mem_ack    = 1'b0;
            mem_data   = $urandom;
            if (rst || !mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt >= gap) begin
                mem_ack   = 1'b1;
                mem_data  = mem[mem_addr[AW-1:2]];
                wait_cnt  = 0;
                ack_total = ack_total + 1;
                flush_resp = (ack_total == flush_at);
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    function automatic int idx_of(input logic [AW-1:0] a);
        return (int'(a) / (4 * LW)) % NL;
    endfunction

    function automatic int tag_of(input logic [AW-1:0] a);
        return int'(a) / (4 * LW * NL);
    endfunction

    function automatic bit resident(input logic [AW-1:0] a);
        return model_valid[idx_of(a)] && (model_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) model_valid[i] = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Fetch one address and follow it cycle by cycle until it hits.
    task automatic applyStimulus(input logic [AW-1:0] a, input int sf, input int sl,
                                 input int exp_pen, input string name);
        logic [31:0] w;
        bit          done;
        w    = mem[a[AW-1:2]];
        done = 1'b0;
        addr = a;
        ce   = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            pc_cache_stall = (cyc >= sf) && (cyc < sf + sl);
            #1;
            if (mem_req && mem_ack) ack_log.push_back(mem_addr);
            if (pc_cache_stall) begin
                checkOutput({name, "_sq_inst"}, inst, 32'h0);
                checkOutput({name, "_sq_ce"}, 32'(cache_enable), 32'h0);
                checkOutput({name, "_sq_stall"}, 32'(icache_stall), 32'h0);
            end else if (cyc < exp_pen) begin
                checkOutput({name, "_stall"}, 32'(icache_stall), 32'h1);
            end else begin
                checkOutput({name, "_stall_end"}, 32'(icache_stall), 32'h0);
                checkOutput({name, "_inst"}, inst, swap32(w));
                checkOutput({name, "_ce"}, 32'(cache_enable), 32'(w[25:24] == 2'b11));
                checkOutput({name, "_hit_req"}, 32'(mem_req), 32'h0);
                done = 1'b1;
            end
            @(negedge clk);
        end
        pc_cache_stall = 1'b0;
        checks = checks + 1;
        assert (done) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s_timeout: observed no hit expected hit after %0d cycles", name, exp_pen);
        end
    endtask

    // Fetch with the penalty predicted from residency and memory speed.
    task automatic fetch(input logic [AW-1:0] a, input int sf, input int sl, input string name);
        int exp_pen;
        exp_pen = resident(a) ? 0 : LW * (gap + 1) + 1;
        applyStimulus(a, sf, sl, exp_pen, name);
        model_valid[idx_of(a)] = 1'b1;
        model_tag[idx_of(a)]   = tag_of(a);
    endtask

    task automatic do_flush();
        ce         = 1'b0;
        flush_main = 1'b1;
        #1;
        checkOutput("flush_ce_low_inst", inst, 32'h0);
        checkOutput("flush_ce_low_stall", 32'(icache_stall), 32'h0);
        @(negedge clk);
        flush_main = 1'b0;
        ce         = 1'b1;
        model_clear();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        ce             = 1'b1;
        addr           = '0;
        pc_cache_stall = 1'b0;
        flush_main     = 1'b0;
        gap            = 0;
        flush_at       = -1;
        model_clear();
        for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = $urandom;
        mem[0]                = 32'h13000000;
        mem[17'h200 >> 2]     = 32'h01000000;

        $display("[TB] reset state");
        #1;
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_ce", 32'(cache_enable), 32'h0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_stall_ce1", 32'(icache_stall), 32'h1);
        ce = 1'b0;
        #1;
        checkOutput("rst_stall_ce0", 32'(icache_stall), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;

        $display("[TB] cold miss and same-line hits");
        ack_log.delete();
        fetch(17'h0, 0, 0, "cold");
        checkOutput("cold_log_n", 32'(ack_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) checkOutput("cold_log_addr", 32'(ack_log[k]), 32'(k * 4));
        #1;
        checkOutput("cold_inst_value", inst, 32'h00000013);
        checkOutput("cold_ce_value", 32'(cache_enable), 32'h1);
        fetch(17'h4, 0, 0, "hit4");
        fetch(17'h8, 0, 0, "hit8");
        fetch(17'hC, 0, 0, "hitC");

        $display("[TB] conflict miss");
        ack_log.delete();
        fetch(17'h100, 0, 0, "conflict");
        checkOutput("conflict_base", 32'(ack_log[0]), 32'h100);
        fetch(17'h0, 0, 0, "refetch0");

        $display("[TB] flush after fill");
        do_flush();
        fetch(17'h0, 0, 0, "post_flush");

        $display("[TB] flush on third refill ack");
        flush_at = ack_total + 3;
        applyStimulus(17'h40, 0, 0, 2 * (LW + 1), "flush_mid");
        flush_at = -1;
        model_clear();
        model_valid[idx_of(17'h40)] = 1'b1;
        model_tag[idx_of(17'h40)]   = tag_of(17'h40);
        fetch(17'h44, 0, 0, "flush_mid_hit");

        $display("[TB] slow memory");
        gap = 2;
        applyStimulus(17'h80, 0, 0, 13, "slow");
        model_valid[idx_of(17'h80)] = 1'b1;
        model_tag[idx_of(17'h80)]   = tag_of(17'h80);
        gap = 0;

        $display("[TB] squash during refill");
        fetch(17'hC0, 2, 2, "squash");

        $display("[TB] 16-bit encoding");
        fetch(17'h200, 0, 0, "decode");
        #1;
        checkOutput("decode_inst_value", inst, 32'h00000001);
        checkOutput("decode_ce_value", 32'(cache_enable), 32'h0);

        $display("[TB] reset mid refill");
        @(negedge clk);
        addr = 17'h300;
        ce   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("midrst_inst", inst, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        fetch(17'h300, 0, 0, "after_rst");

        $display("[TB] random fetches");
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            int            sf;
            int            sl;
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) do_flush();
            a  = AW'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
                     ($urandom_range(0, 3) << 2));
            sf = $urandom_range(1, 4);
            sl = $urandom_range(0, 2);
            fetch(a, sf, sl, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
